// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Iterative shift-add multiply and restoring divide on magnitudes; signs are fixed up in StFin.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMsub  = 3'b101;
  localparam logic [2:0] OpMthi  = 3'b110;
  localparam logic [2:0] OpMtlo  = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hw_q, hw_d;
  logic [WIDTH-1:0]   lw_q, lw_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic               accept;
  logic               in_signed, in_mul, in_div, in_iter;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               q_div;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] fast_prod, prod_mag, prod_s, hilo, hilo_new;

  assign accept    = Start && (state_q == StIdle);
  assign in_signed = (Op == OpMult) || (Op == OpDiv) || (Op == OpMadd) || (Op == OpMsub);
  assign in_mul    = (Op == OpMult) || (Op == OpMultu) || (Op == OpMadd) || (Op == OpMsub);
  assign in_div    = (Op == OpDiv) || (Op == OpDivu);
  assign in_iter   = (in_mul && (FAST_MUL == 0)) || (in_div && (B != '0));
  assign sign_a    = in_signed && A[WIDTH-1];
  assign sign_b    = in_signed && B[WIDTH-1];
  assign a_mag     = sign_a ? -A : A;
  assign b_mag     = sign_b ? -B : B;
  assign q_div     = (op_q == OpDiv) || (op_q == OpDivu);

  // One shift-add step: low word holds the remaining multiplier bits.
  assign mul_sum   = {1'b0, hw_q} + (lw_q[0] ? {1'b0, b_q} : '0);
  // One restoring step: low word shifts dividend bits out and quotient bits in.
  assign rem_sh    = {hw_q, lw_q[WIDTH-1]};
  assign rem_diff  = rem_sh - {1'b0, b_q};

  assign fast_prod = {{WIDTH{1'b0}}, lw_q} * {{WIDTH{1'b0}}, b_q};
  assign prod_mag  = (FAST_MUL != 0) ? fast_prod : {hw_q, lw_q};
  assign prod_s    = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
  assign hilo      = {hi_q, lo_q};
  assign hilo_new  = (op_q == OpMadd) ? hilo + prod_s :
                     (op_q == OpMsub) ? hilo - prod_s : prod_s;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OpMult;
      a_q       <= '0;
      b_q       <= '0;
      hw_q      <= '0;
      lw_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hw_q      <= hw_d;
      lw_q      <= lw_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = in_iter ? StRun : StFin;
      StRun:   if (cnt_q == CntW'(WIDTH - 1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hw_d      = hw_q;
    lw_d      = lw_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d     = '0;
          op_d      = Op;
          a_d       = A;
          b_d       = b_mag;
          hw_d      = '0;
          lw_d      = a_mag;
          sa_d      = sign_a;
          sb_d      = sign_b;
          dz_d      = in_div && (B == '0);
          divzero_d = 1'b0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (q_div) begin
          if (!rem_diff[WIDTH]) begin
            hw_d = rem_diff[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], 1'b1};
          end else begin
            hw_d = rem_sh[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hw_d = mul_sum[WIDTH:1];
          lw_d = {mul_sum[0], lw_q[WIDTH-1:1]};
        end
      end
      StFin: begin
        done_d = 1'b1;
        case (op_q)
          OpMthi: hi_d = a_q;
          OpMtlo: lo_d = a_q;
          OpDiv, OpDivu: begin
            if (dz_q) begin
              hi_d      = a_q;
              lo_d      = '1;
              divzero_d = 1'b1;
            end else begin
              lo_d = (sa_q ^ sb_q) ? -lw_q : lw_q;
              hi_d = sa_q ? -hw_q : hw_q;
            end
          end
          default: {hi_d, lo_d} = hilo_new;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy    = (state_q != StIdle);
    Done    = done_q;
    DivZero = divzero_q;
    Hi      = hi_q;
    Lo      = lo_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops them on Done.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;

  logic         f_start = 1'b0;
  logic [2:0]   f_op = 3'b001;
  logic [W-1:0] f_a = '0, f_b = '0;
  logic         f_busy, f_done, f_dz;
  logic [W-1:0] f_hi, f_lo;

  exp_t         sb_q[$];
  logic [W-1:0] mdl_hi = '0, mdl_lo = '0;
  logic [W-1:0] cur_hi = '0, cur_lo = '0;
  int           total = 0, bad = 0;
  int           cyc = 0, acc_cyc = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W), .FAST_MUL(0)) u_dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .DivZero(divzero), .Hi(hi), .Lo(lo)
  );

  hilo_muldiv_unit #(.WIDTH(W), .FAST_MUL(1)) u_fast (
    .Clk(clk), .Reset(rst_n), .Start(f_start), .Op(f_op), .A(f_a), .B(f_b),
    .Busy(f_busy), .Done(f_done), .DivZero(f_dz), .Hi(f_hi), .Lo(f_lo)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    longint sx, sy, p;
    logic [63:0] ux, uy, hl;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    hl = {mdl_hi, mdl_lo};
    e.dz = 1'b0;
    e.lat = W + 1;
    case (o)
      3'd0: hl = sx * sy;
      3'd1: hl = ux * uy;
      3'd4: begin p = sx * sy; hl = hl + p; end
      3'd5: begin p = sx * sy; hl = hl - p; end
      3'd2, 3'd3: begin
        if (y == 0) begin
          hl = {x, 32'hFFFF_FFFF};
          e.dz = 1'b1;
          e.lat = 1;
        end else if (o == 3'd2) begin
          hl = {32'(sx % sy), 32'(sx / sy)};
        end else begin
          hl = {32'(ux % uy), 32'(ux / uy)};
        end
      end
      3'd6: begin hl[63:32] = x; e.lat = 1; end
      default: begin hl[31:0] = x; e.lat = 1; end
    endcase
    mdl_hi = hl[63:32];
    mdl_lo = hl[31:0];
    e.hi = mdl_hi;
    e.lo = mdl_lo;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n);
    end
    model(o, x, y, e);
    sb_q.push_back(e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb_q.size());
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && !busy) acc_cyc = cyc;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no result pending");
      end else begin
        e = sb_q.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
        chk("divzero", {63'b0, divzero}, {63'b0, e.dz});
        chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end else if (rst_n && busy) begin
      chk("hilo_hold", {hi, lo}, {cur_hi, cur_lo});
    end
  end

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'b0, busy, done, divzero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFB, 32'd3);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'd5, 32'd0);
    issue(3'd0, 32'd9, 32'd9);
    issue(3'd6, 32'h1234_5678, 32'd0);
    issue(3'd7, 32'd0, 32'd0);
    issue(3'd4, 32'd2, 32'd3);
    issue(3'd5, 32'd1, 32'd7);
    wait_idle();

    // A Start during Busy must be dropped without disturbing the running op.
    issue(3'd0, 32'h0000_1234, 32'hFFFF_FF00);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = 3'd6;
    a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // FAST_MUL=1 instance: single-cycle multiply.
    f_start = 1'b1;
    f_op = 3'd1;
    f_a = 32'hFFFF_FFFF;
    f_b = 32'hFFFF_FFFF;
    @(negedge clk);
    f_start = 1'b0;
    chk("fast_busy", {63'b0, f_busy}, 64'd1);
    @(negedge clk);
    chk("fast_done", {63'b0, f_done}, 64'd1);
    chk("fast_hilo", {f_hi, f_lo}, 64'hFFFF_FFFE_0000_0001);

    // Reset in the middle of a divide aborts it.
    issue(3'd2, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_flags", {61'b0, busy, done, divzero}, 64'd0);
    sb_q.delete();
    mdl_hi = '0;
    mdl_lo = '0;
    cur_hi = '0;
    cur_lo = '0;
    rst_n = 1'b1;
    issue(3'd3, 32'd100, 32'd7);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      issue(ro, ra, rb);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
